// File: rtl/transition_event_logger.sv
// Measures pulses on pulse_in and queues {start timestamp, width} records in a small FIFO.
// Optional saturating drop counter on the drop_count port when TEL_DROP_COUNT_EN is defined.
module transition_event_logger #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_SAT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pulse_in,
  input  logic        evt_ready,
  input  logic        clr_ovf,
  output logic        evt_valid,
  output logic [23:0] evt_data,
  output logic [15:0] evt_count,
  output logic        overflow
`ifdef TEL_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int            AW    = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [7:0]    WSAT  = 8'(WIDTH_SAT);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, IN_PULSE} state_t;

  state_t      state, state_nxt;
  logic [15:0] ts;
  logic [15:0] start, start_nxt;
  logic [7:0]  width, width_nxt;
  logic        pulse_hi;
  logic        push;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, pop, accept, drop;

  assign pulse_hi = |pulse_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_LOW;
      ts    <= '0;
      start <= '0;
      width <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + 16'd1;
      start <= start_nxt;
      width <= width_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = start;
    width_nxt = width;
    push      = 1'b0;
    case (state)
      WAIT_LOW: if (!pulse_hi) state_nxt = IDLE;
      IDLE: begin
        if (pulse_hi) begin
          state_nxt = IN_PULSE;
          start_nxt = ts;
          width_nxt = 8'd1;
        end
      end
      IN_PULSE: begin
        if (pulse_hi) begin
          if (width < WSAT) width_nxt = width + 8'd1;
        end else begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  // A pop frees the slot the incoming record needs, so push-while-full still fits.
  assign full   = (occ == FULL);
  assign pop    = evt_valid & evt_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign evt_valid = (occ != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 24'd0;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {start, width};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + AW'(1);
        evt_count <= evt_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef TEL_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                           drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_transition_event_logger.sv
// Directed bench for transition_event_logger: table of pulses plus multi-cycle FIFO corner sequences.
module tb_transition_event_logger;

  logic        clk;
  logic        reset;
  logic [31:0] pulse_in;
  logic        evt_ready;
  logic        clr_ovf;
  logic        evt_valid;
  logic [23:0] evt_data;
  logic [15:0] evt_count;
  logic        overflow;
`ifdef TEL_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  transition_event_logger dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_count (evt_count),
    .overflow  (overflow)
`ifdef TEL_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          len;
    logic [7:0]  exp_width;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          tb_ts  = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tb_ts = 0;
  endtask

  // Holds pulse_in at val for len sampled cycles, then drives it low (not yet sampled).
  task automatic do_pulse(input logic [31:0] val, input int len, output logic [15:0] start);
    pulse_in = val;
    start    = 16'(tb_ts);
    repeat (len) step();
    pulse_in = 32'd0;
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk({name, "_valid"}, {31'd0, evt_valid}, 32'd1);
      chk({name, "_data"}, {8'd0, evt_data}, {8'd0, exp_q.pop_front()});
      step();
    end
    evt_ready = 1'b0;
    chk({name, "_empty"}, {31'd0, evt_valid}, 32'd0);
    chk({name, "_data0"}, {8'd0, evt_data}, 32'd0);
  endtask

  vec_t        vecs[8];
  logic [15:0] s;

  initial begin
    vecs[0] = '{32'h0000_0001,   1, 8'd1};
    vecs[1] = '{32'h8000_0000,   3, 8'd3};
    vecs[2] = '{32'hFFFF_FFFF,   7, 8'd7};
    vecs[3] = '{32'h0001_0000,   2, 8'd2};
    vecs[4] = '{32'h0000_0100, 255, 8'd255};
    vecs[5] = '{32'h0000_0001, 256, 8'd255};
    vecs[6] = '{32'h0000_0004, 300, 8'd255};
    vecs[7] = '{32'h0000_0002, 254, 8'd254};

    pulse_in  = 32'd0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    reset     = 1'b1;

    do_reset();
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_data",  {8'd0, evt_data},   32'd0);
    chk("rst_count", {16'd0, evt_count}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow},  32'd0);
`ifdef TEL_DROP_COUNT_EN
    chk("rst_drop",  {16'd0, drop_count}, 32'd0);
`endif

    // Pulse at timestamps 10..13 with the consumer always ready.
    evt_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      pulse_in = (tb_ts >= 10 && tb_ts <= 13) ? 32'd1 : 32'd0;
      step();
      if (tb_ts == 14) chk("s1_not_yet", {31'd0, evt_valid}, 32'd0);
    end
    chk("s1_valid", {31'd0, evt_valid}, 32'd1);
    chk("s1_data",  {8'd0, evt_data},   32'h000A04);
    chk("s1_count", {16'd0, evt_count}, 32'd1);
    step();
    chk("s1_popped", {31'd0, evt_valid}, 32'd0);
    chk("s1_data0",  {8'd0, evt_data},   32'd0);
    evt_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_pulse(vecs[i].val, vecs[i].len, s);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, evt_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i),  {8'd0, evt_data},   {8'd0, s, vecs[i].exp_width});
      chk($sformatf("vec%0d_count", i), {16'd0, evt_count}, 32'(i + 2));
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      chk($sformatf("vec%0d_pop", i), {31'd0, evt_valid}, 32'd0);
    end

    // Pulse already high across reset release must not be logged.
    pulse_in = 32'd1;
    do_reset();
    chk("s2_rst_count", {16'd0, evt_count}, 32'd0);
    repeat (5) step();
    pulse_in = 32'd0;
    repeat (3) step();
    chk("s2_valid", {31'd0, evt_valid}, 32'd0);
    chk("s2_count", {16'd0, evt_count}, 32'd0);

    // Ten pulses into an eight-entry FIFO with no consumer.
    for (int k = 0; k < 10; k++) begin
      do_pulse(32'd1, 4, s);
      step();
      if (k < 8) exp_q.push_back({s, 8'd4});
      if (k == 7) chk("s4_ovf_before", {31'd0, overflow}, 32'd0);
    end
    chk("s4_ovf",   {31'd0, overflow},  32'd1);
    chk("s4_count", {16'd0, evt_count}, 32'd8);
`ifdef TEL_DROP_COUNT_EN
    chk("s4_drop",  {16'd0, drop_count}, 32'd2);
`endif
    repeat (2) step();
    chk("s4_hold_valid", {31'd0, evt_valid}, 32'd1);
    chk("s4_hold_data",  {8'd0, evt_data},   {8'd0, exp_q[0]});

    // Full FIFO: push and pop on the same edge.
    do_pulse(32'd1, 3, s);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({s, 8'd3});
    chk("s5_count", {16'd0, evt_count}, 32'd9);
    chk("s5_ovf",   {31'd0, overflow},  32'd1);
    chk("s5_head",  {8'd0, evt_data},   {8'd0, exp_q[0]});
`ifdef TEL_DROP_COUNT_EN
    chk("s5_drop",  {16'd0, drop_count}, 32'd2);
`endif

    // clr_ovf coinciding with a drop: set wins.
    do_pulse(32'd1, 2, s);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("s6_set_wins", {31'd0, overflow},  32'd1);
    chk("s6_count",    {16'd0, evt_count}, 32'd9);
`ifdef TEL_DROP_COUNT_EN
    chk("s6_drop",     {16'd0, drop_count}, 32'd3);
`endif
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("s6_clear", {31'd0, overflow}, 32'd0);

    drain("s5_drain");
    chk("end_count", {16'd0, evt_count}, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
